// File: rtl/mam_wb_pkg.sv
// Shared constants, state encoding and helpers for the MAM-to-Wishbone burst bridge.
package mam_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // A single-beat request, or a burst of zero beats, both move exactly one word.
    function automatic logic [13:0] eff_beats(input logic burst, input logic [13:0] beats);
        return (burst && beats != 14'd0) ? beats : 14'd1;
    endfunction

endpackage

// File: rtl/mam_wb_rdfifo.sv
// First-word-fall-through read buffer; exposes its free-entry count so the bus side
// only strobes a read beat when the returning word is guaranteed a slot.
module mam_wb_rdfifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit, so their difference is the fill level directly.
    assign used     = wr_ptr - rd_ptr;
    assign empty    = (used == '0);
    assign full     = (used == CAP);
    assign free     = CAP - used;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mam_wb_burst_if.sv
// MAM request/write/read channels to a Wishbone B3 master with classic or incrementing
// bursts, buffered reads, retry/timeout handling and an error pulse.
module mam_wb_burst_if
    import mam_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 32,
    parameter int BURST_EN      = 1,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT       = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Every channel is valid/ready: a word moves on the rising edge where both are high;
    // valid, once raised, holds with stable payload until ready is seen.
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,
    input  logic                    write_valid,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,
    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_ready,
    output logic                    err,
    output logic                    CYC_O,
    output logic                    STB_O,
    output logic                    WE_O,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    output logic [2:0]              CTI_O,
    output logic [1:0]              BTE_O,
    input  logic                    ACK_I,
    input  logic                    ERR_I,
    input  logic                    RTY_I,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    output state_e                  dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int FW    = $clog2(RD_FIFO_DEPTH);
    localparam int RW    = $clog2(MAX_RETRY + 2);
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  rw_q, rw_nxt;
    logic [13:0]           beats_q, beats_nxt;
    logic [RW-1:0]         retry_q, retry_nxt;
    logic [TW-1:0]         tmo_q, tmo_nxt;
    logic                  err_q, err_nxt;
    logic                  last_beat;
    logic                  fail;

    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic [FW:0]           fifo_free;

    mam_wb_rdfifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rdfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    assign read_valid = ~fifo_empty;
    assign read_data  = read_valid ? fifo_rdata : '0;
    assign fifo_pop   = read_valid & read_ready;
    assign err        = err_q;
    assign BTE_O      = BTE_LINEAR;
    assign dbg_state  = state;
    assign last_beat  = (beats_q == 14'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            beats_q <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            rw_q    <= rw_nxt;
            beats_q <= beats_nxt;
            retry_q <= retry_nxt;
            tmo_q   <= tmo_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        rw_nxt      = rw_q;
        beats_nxt   = beats_q;
        retry_nxt   = retry_q;
        tmo_nxt     = tmo_q;
        err_nxt     = 1'b0;
        fail        = 1'b0;
        req_ready   = 1'b0;
        write_ready = 1'b0;
        fifo_push   = 1'b0;
        fifo_wdata  = '0;
        CYC_O       = 1'b0;
        STB_O       = 1'b0;
        WE_O        = 1'b0;
        ADR_O       = '0;
        DAT_O       = '0;
        SEL_O       = '0;
        CTI_O       = CTI_CLASSIC;

        case (state)
            IDLE: begin
                // Holding off new requests until buffered read words are gone keeps
                // responses of consecutive requests from interleaving.
                req_ready = fifo_empty;
                if (req_valid && fifo_empty) begin
                    addr_nxt  = req_addr;
                    rw_nxt    = req_rw;
                    beats_nxt = eff_beats(req_burst, req_beats);
                    retry_nxt = '0;
                    tmo_nxt   = '0;
                    state_nxt = req_rw ? WRITE : READ;
                end
            end

            WRITE, READ: begin
                CYC_O = 1'b1;
                ADR_O = addr_q;
                if (BURST_EN != 0) CTI_O = last_beat ? CTI_EOB : CTI_INCR;
                if (state == WRITE) begin
                    STB_O = write_valid;
                    WE_O  = write_valid;
                    DAT_O = write_data;
                    SEL_O = write_strb;
                end else begin
                    STB_O = (fifo_free != '0);
                    SEL_O = '1;
                end

                // Response priority ERR > RTY > ACK; responses without STB_O are ignored.
                if (STB_O) begin
                    if (ERR_I) begin
                        fail = 1'b1;
                    end else if (RTY_I) begin
                        tmo_nxt = '0;
                        if (retry_q == RW'(MAX_RETRY)) fail = 1'b1;
                        else                           retry_nxt = retry_q + 1'b1;
                    end else if (ACK_I) begin
                        tmo_nxt     = '0;
                        retry_nxt   = '0;
                        addr_nxt    = addr_q + ADDR_WIDTH'(BYTES);
                        beats_nxt   = beats_q - 14'd1;
                        write_ready = (state == WRITE);
                        fifo_push   = (state == READ);
                        fifo_wdata  = DAT_I;
                        if (last_beat) state_nxt = IDLE;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        fail = 1'b1;
                    end else begin
                        tmo_nxt = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_nxt = '0;
                end

                // The failed beat stays in beats_q: its write word is still pending and
                // its read word was never delivered, so DRAIN settles it with the rest.
                if (fail) begin
                    err_nxt   = 1'b1;
                    retry_nxt = '0;
                    tmo_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                if (rw_q) begin
                    write_ready = write_valid;
                    if (write_valid) begin
                        beats_nxt = beats_q - 14'd1;
                        if (last_beat) state_nxt = IDLE;
                    end
                end else begin
                    fifo_push = (fifo_free != '0);
                    if (fifo_push) begin
                        beats_nxt = beats_q - 14'd1;
                        if (last_beat) state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
